// File: rtl/theta_gen_pkg.sv
// Shared constants, FSM encoding and fixed-point helpers for the theta_gen phase generator.
// THETA_OFFSET_EN adds the OFFSET state used for a constant phase offset.
package theta_gen_pkg;

    localparam int          SINGLE   = 32;
    localparam int          Q_FRAC   = 29;
    localparam logic [31:0] TWO_PI_Q = 32'hC90FDAA2;
    localparam logic [7:0]  EXP_ADJ  = 8'(127 - Q_FRAC);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADD    = 3'd1,
        ST_WRAP   = 3'd2,
`ifdef THETA_OFFSET_EN
        ST_OFFSET = 3'd3,
`endif
        ST_NORM   = 3'd4,
        ST_PACK   = 3'd5
    } state_t;

    // Both operands of the sum are below 2*pi, so a single conditional subtract suffices.
    function automatic logic [31:0] wrap_2pi(input logic [32:0] s);
        if (s >= {1'b0, TWO_PI_Q})
            return 32'(s - {1'b0, TWO_PI_Q});
        return s[31:0];
    endfunction

    function automatic logic [4:0] lead_one(input logic [31:0] v);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 32; i++)
            if (v[i]) p = 5'(i);
        return p;
    endfunction

endpackage

// File: rtl/theta_gen_if.sv
// Request/result bundle between a phase-step requester (master) and theta_gen (slave).
// THETA_OFFSET_EN adds the phase_off operand.
interface theta_gen_if;
    import theta_gen_pkg::*;

    logic              step;
    logic              load;
    logic [31:0]       dtheta;
    logic [31:0]       phase_init;
`ifdef THETA_OFFSET_EN
    logic [31:0]       phase_off;
`endif
    logic [SINGLE-1:0] theta;
    logic              theta_valid;
    logic              busy;
    logic              ovr;
    logic              err;

    modport master (
`ifdef THETA_OFFSET_EN
        output phase_off,
`endif
        output step, load, dtheta, phase_init,
        input  theta, theta_valid, busy, ovr, err
    );

    modport slave (
`ifdef THETA_OFFSET_EN
        input  phase_off,
`endif
        input  step, load, dtheta, phase_init,
        output theta, theta_valid, busy, ovr, err
    );

endinterface

// File: rtl/theta_gen_fix2float_q329.sv
// Unsigned Q3.29 to IEEE-754 single conversion: leading-one search registered in NORM,
// truncated pack registered in PACK. The packed word holds between PACK cycles.
module fix2float_q329
    import theta_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_norm_en,
    input  logic              i_pack_en,
    input  logic [31:0]       i_v,
    output logic [SINGLE-1:0] o_theta
);

    logic [31:0]       r_v;
    logic [4:0]        r_p;
    logic [SINGLE-1:0] r_theta;
    logic [22:0]       w_mant;
    logic [SINGLE-1:0] w_float;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_mant  = 23'({r_v << (5'd31 - r_p)} >> 8);
        w_float = {1'b0, {3'b000, r_p} + EXP_ADJ, w_mant};
        if (r_v == '0)
            w_float = '0;
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r_p     <= '0;
            r_theta <= '0;
        end else begin
            if (i_norm_en) begin
                r_v <= i_v;
                r_p <= lead_one(i_v);
            end
            if (i_pack_en)
                r_theta <= w_float;
        end
    end

    assign o_theta = r_theta;

endmodule

// File: rtl/theta_gen.sv
// Phase accumulator with mod-2*pi wrap and float output, one request per timestep.
// Optional feature macro: THETA_OFFSET_EN (phase_off input plus OFFSET state).
module theta_gen
    import theta_gen_pkg::*;
(
    input logic       clk,
    input logic       rst,
    theta_gen_if.slave tg
);

    state_t      r_state;
    logic [31:0] r_acc;
    logic [31:0] r_opnd;
    logic [32:0] r_sum;
    logic        r_is_load;
    logic        r_busy;
    logic        r_valid;
    logic        r_ovr;
    logic        r_err;
    logic        w_req;
    logic        w_bad;
    logic [31:0] w_v;

`ifdef THETA_OFFSET_EN
    logic [31:0] r_off;
    logic [31:0] r_v;
    assign w_v = r_v;
`else
    assign w_v = r_acc;
`endif

    assign w_req = tg.step | tg.load;

    // load wins over step, so only the operand that will actually be used is range-checked.
    always_comb begin
        w_bad = tg.load ? (tg.phase_init >= TWO_PI_Q) : (tg.dtheta >= TWO_PI_Q);
`ifdef THETA_OFFSET_EN
        w_bad = w_bad | (tg.phase_off >= TWO_PI_Q);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_sum     <= '0;
            r_is_load <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_ovr     <= 1'b0;
            r_err     <= 1'b0;
`ifdef THETA_OFFSET_EN
            r_off     <= '0;
            r_v       <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (w_req && r_busy)
                r_ovr <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    // busy stays up through the strobe cycle, then drops here.
                    r_busy <= 1'b0;
                    if (w_req && !r_busy) begin
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_opnd    <= tg.load ? tg.phase_init : tg.dtheta;
                            r_is_load <= tg.load;
`ifdef THETA_OFFSET_EN
                            r_off     <= tg.phase_off;
`endif
                            r_busy    <= 1'b1;
                            r_state   <= ST_ADD;
                        end
                    end
                end
                ST_ADD: begin
                    r_sum   <= r_is_load ? {1'b0, r_opnd} : {1'b0, r_acc} + {1'b0, r_opnd};
                    r_state <= ST_WRAP;
                end
                ST_WRAP: begin
                    r_acc   <= wrap_2pi(r_sum);
`ifdef THETA_OFFSET_EN
                    r_state <= ST_OFFSET;
                end
                ST_OFFSET: begin
                    r_v     <= wrap_2pi({1'b0, r_acc} + {1'b0, r_off});
`endif
                    r_state <= ST_NORM;
                end
                ST_NORM: r_state <= ST_PACK;
                ST_PACK: begin
                    r_valid <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    fix2float_q329 u_f2f (
        .clk       (clk),
        .rst       (rst),
        .i_norm_en (r_state == ST_NORM),
        .i_pack_en (r_state == ST_PACK),
        .i_v       (w_v),
        .o_theta   (tg.theta)
    );

    assign tg.theta_valid = r_valid;
    assign tg.busy        = r_busy;
    assign tg.ovr         = r_ovr;
    assign tg.err         = r_err;

endmodule

// File: tb/tb_theta_gen.sv
// Directed self-checking bench for theta_gen; expected words are hand-computed Q3.29/float values.
// Works in both the default build and with THETA_OFFSET_EN defined.
module tb_theta_gen;

`ifdef THETA_OFFSET_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   cnt;

    theta_gen_if tg ();

    theta_gen dut (
        .clk (clk),
        .rst (rst),
        .tg  (tg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic s, input logic l, input logic [31:0] d, input logic [31:0] p);
        @(negedge clk);
        tg.step       = s;
        tg.load       = l;
        tg.dtheta     = d;
        tg.phase_init = p;
        @(negedge clk);
        tg.step       = 1'b0;
        tg.load       = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tg.theta_valid) begin
                c = i;
                break;
            end
        end
    endtask

    task automatic count_strobes(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tg.theta_valid) c++;
        end
    endtask

    task automatic do_op(input string tag, input logic s, input logic l,
                         input logic [31:0] d, input logic [31:0] p,
                         input logic [31:0] exp_theta, input logic [31:0] exp_acc);
        int c;
        pulse(s, l, d, p);
        check({tag, "_busy_rise"}, 32'(tg.busy), 32'd1);
        wait_valid(c);
        check({tag, "_latency"}, 32'(c), 32'(LAT));
        check({tag, "_theta"}, tg.theta, exp_theta);
        check({tag, "_acc"}, dut.r_acc, exp_acc);
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(tg.theta_valid), 32'd0);
        check({tag, "_busy_fall"}, 32'(tg.busy), 32'd0);
        check({tag, "_theta_hold"}, tg.theta, exp_theta);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        tg.step       = 1'b0;
        tg.load       = 1'b0;
        tg.dtheta     = '0;
        tg.phase_init = '0;
`ifdef THETA_OFFSET_EN
        tg.phase_off  = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_theta", tg.theta, 32'h0);
        check("rst_valid", 32'(tg.theta_valid), 32'd0);
        check("rst_busy", 32'(tg.busy), 32'd0);
        check("rst_ovr", 32'(tg.ovr), 32'd0);
        check("rst_err", 32'(tg.err), 32'd0);
        check("rst_acc", dut.r_acc, 32'h0);
        rst = 1'b0;

        // Four pi/2 steps: the fourth crosses 2*pi and leaves 2 LSBs of residue.
        do_op("step1", 1'b1, 1'b0, 32'h3243F6A9, 32'h0, 32'h3FC90FDA, 32'h3243F6A9);
        do_op("step2", 1'b1, 1'b0, 32'h3243F6A9, 32'h0, 32'h40490FDA, 32'h6487ED52);
        do_op("step3", 1'b1, 1'b0, 32'h3243F6A9, 32'h0, 32'h4096CBE3, 32'h96CBE3FB);
        do_op("step4", 1'b1, 1'b0, 32'h3243F6A9, 32'h0, 32'h31800000, 32'h00000002);
        check("wrap_ovr", 32'(tg.ovr), 32'd0);

        do_op("load_pri", 1'b1, 1'b1, 32'h3243F6A9, 32'h6487ED51, 32'h40490FDA, 32'h6487ED51);
        check("load_pri_ovr", 32'(tg.ovr), 32'd0);

        // Second step lands while the first is still in flight.
        pulse(1'b1, 1'b0, 32'h3243F6A9, 32'h0);
        @(negedge clk);
        pulse(1'b1, 1'b0, 32'h3243F6A9, 32'h0);
        check("ovr_set", 32'(tg.ovr), 32'd1);
        count_strobes(12, cnt);
        check("ovr_strobes", 32'(cnt), 32'd1);
        check("ovr_acc", dut.r_acc, 32'h96CBE3FA);
        check("ovr_theta", tg.theta, 32'h4096CBE3);

        pulse(1'b1, 1'b0, 32'hC90FDAA2, 32'h0);
        check("err_busy", 32'(tg.busy), 32'd0);
        count_strobes(8, cnt);
        check("err_strobes", 32'(cnt), 32'd0);
        check("err_set", 32'(tg.err), 32'd1);
        check("err_acc", dut.r_acc, 32'h96CBE3FA);

        apply_reset();
        check("rst2_ovr", 32'(tg.ovr), 32'd0);
        check("rst2_err", 32'(tg.err), 32'd0);
        check("rst2_acc", dut.r_acc, 32'h0);

        // Largest legal phase is accepted.
        do_op("load_max", 1'b0, 1'b1, 32'h0, 32'hC90FDAA1, 32'h40C90FDA, 32'hC90FDAA1);
        check("load_max_err", 32'(tg.err), 32'd0);

        // Abort in the NORM cycle.
        pulse(1'b1, 1'b0, 32'h3243F6A9, 32'h0);
        repeat (LAT - 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_theta", tg.theta, 32'h0);
        check("abort_busy", 32'(tg.busy), 32'd0);
        check("abort_acc", dut.r_acc, 32'h0);
        count_strobes(8, cnt);
        check("abort_strobes", 32'(cnt), 32'd0);
        check("abort_theta_after", tg.theta, 32'h0);

`ifdef THETA_OFFSET_EN
        tg.phase_off = 32'h6487ED51;
        do_op("zero_step", 1'b1, 1'b0, 32'h0, 32'h0, 32'h40490FDA, 32'h0);
        tg.phase_off = 32'hC90FDAA2;
        pulse(1'b1, 1'b0, 32'h0, 32'h0);
        check("off_err_busy", 32'(tg.busy), 32'd0);
        check("off_err_set", 32'(tg.err), 32'd1);
        tg.phase_off = '0;
`else
        do_op("zero_step", 1'b1, 1'b0, 32'h0, 32'h0, 32'h00000000, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
